// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage of the RISC-V core. Owns the program counter,
//   drives the instruction-memory word address (Dir) and samples the returned
//   instruction into the IF/ID pipeline register. Handles sequential fetch,
//   stall, flush, control-flow redirect and a halt on EBREAK.
//
//   Optional feature macro: FETCH_MISALIGN_TRAP_EN
//     defined   : adds the Misalign output; a redirect to a target whose low
//                 two bits are non-zero halts fetch and raises Misalign.
//     undefined : no Misalign port; redirect targets are word-aligned by
//                 forcing bits [1:0] to zero.
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IMEM_AW  = 8
) (
  input  logic        CLK,
  input  logic        RST,
  output logic [31:0] Dir,
  input  logic [31:0] Inst_in,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        Redirect,
  input  logic [31:0] Redirect_PC,
  output logic [31:0] Inst_out,
  output logic [31:0] PC_out,
  output logic [31:0] PC4_out,
  output logic        Valid_out,
  output logic        Halted
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic        Misalign
`endif
);

  // Encodings the stage recognises or emits on its own.
  localparam logic [31:0] INSN_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INSN_NOP    = 32'h0000_0013;
  localparam logic [31:0] PC_STEP     = 32'h0000_0004;

  // One-hot style two-bit encoding: any corrupted value is caught by the
  // default branch and steered back to RUN.
  typedef enum logic [1:0] {
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic [31:0] pc4_out_q, pc4_out_d;
  logic        valid_q, valid_d;

  logic [31:0] pc_plus4_s;
  logic [31:0] redirect_tgt_s;
  logic        is_ebreak_s;
  logic        redirect_misaligned_s;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic        misalign_q, misalign_d;
`endif

  // Sequential PC, modulo 2^32.
  assign pc_plus4_s  = pc_q + PC_STEP;
  assign is_ebreak_s = (Inst_in == INSN_EBREAK);

`ifdef FETCH_MISALIGN_TRAP_EN
  // Target is loaded verbatim; a misaligned one is trapped below.
  assign redirect_tgt_s        = Redirect_PC;
  assign redirect_misaligned_s = (Redirect_PC[1:0] != 2'b00);
`else
  // No trap available: silently word-align the target.
  assign redirect_tgt_s        = Redirect_PC & ~32'h0000_0003;
  assign redirect_misaligned_s = 1'b0;
`endif

  // Memory word address comes straight from the PC register only, so no
  // handshake input has a combinational path to Dir. Upper PC bits alias.
  assign Dir = {{(32-IMEM_AW){1'b0}}, pc_q[IMEM_AW+1:2]};

  // Next-state and IF/ID update logic; everything holds unless a case below
  // says otherwise.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    pc_out_d  = pc_out_q;
    pc4_out_d = pc4_out_q;
    valid_d   = valid_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    misalign_d = misalign_q;
`endif

    case (state_q)
      ST_RUN: begin
        if (Redirect) begin
          // Redirect wins over stall and flush; the old IF/ID contents
          // become a bubble but keep their data fields.
          pc_d    = redirect_tgt_s;
          valid_d = 1'b0;
          if (redirect_misaligned_s) begin
            state_d = ST_HALT;
          end else begin
            state_d = ST_RUN;
          end
`ifdef FETCH_MISALIGN_TRAP_EN
          misalign_d = redirect_misaligned_s;
`endif
        end else if (Stall) begin
          // Hold PC and IF/ID; a simultaneous flush still kills the entry.
          if (Flush) begin
            valid_d = 1'b0;
          end else begin
            valid_d = valid_q;
          end
        end else if (Flush) begin
          pc_d    = pc_plus4_s;
          valid_d = 1'b0;
        end else begin
          inst_d    = Inst_in;
          pc_out_d  = pc_q;
          pc4_out_d = pc_plus4_s;
          valid_d   = 1'b1;
          if (is_ebreak_s) begin
            // EBREAK is delivered, then fetch parks on its address.
            state_d = ST_HALT;
            pc_d    = pc_q;
          end else begin
            pc_d = pc_plus4_s;
          end
        end
      end

      ST_HALT: begin
        if (Redirect) begin
          pc_d    = redirect_tgt_s;
          valid_d = 1'b0;
          if (redirect_misaligned_s) begin
            state_d = ST_HALT;
          end else begin
            state_d = ST_RUN;
          end
`ifdef FETCH_MISALIGN_TRAP_EN
          misalign_d = redirect_misaligned_s;
`endif
        end else if (Stall) begin
          // Downstream still needs the halting instruction.
          if (Flush) begin
            valid_d = 1'b0;
          end else begin
            valid_d = valid_q;
          end
        end else begin
          // Halting instruction has been consumed; emit bubbles from now on.
          valid_d = 1'b0;
        end
      end

      default: begin
        // Illegal state encoding: recover to RUN with an empty IF/ID.
        state_d = ST_RUN;
        pc_d    = pc_q;
        valid_d = 1'b0;
      end
    endcase
  end

  // State, PC and IF/ID pipeline registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= ST_RUN;
      pc_q      <= RESET_PC;
      inst_q    <= INSN_NOP;
      pc_out_q  <= 32'h0000_0000;
      pc4_out_q <= 32'h0000_0000;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      pc_out_q  <= pc_out_d;
      pc4_out_q <= pc4_out_d;
      valid_q   <= valid_d;
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  // Sticky misaligned-redirect flag.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end

  assign Misalign = misalign_q;
`endif

  // All outputs come directly from registers.
  assign Inst_out  = inst_q;
  assign PC_out    = pc_out_q;
  assign PC4_out   = pc4_out_q;
  assign Valid_out = valid_q;
  assign Halted    = (state_q == ST_HALT);

endmodule
